ulpb_sleep_sched: RTL and testbench

Sleep-entry scheduler placed in front of the ULPB sleep controller; it generates the controller's `SLEEP_REQ` input. It collects per-requester sleep votes and bus/wake activity, enforces a post-wake guard interval and an idle-time qualification, then holds the request until the controller reports isolation engaged. It also counts completed sleep cycles for debug.

---
 rtl/ulpb_sleep_sched.sv | 183 ++++++++++++++++++
 tb/tb_ulpb_sleep_sched.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/ulpb_sleep_sched.sv
// Sleep-entry scheduler driving SLEEP_REQ of the ULPB sleep controller.
// Optional REQ-state timeout is compiled in by defining ULPB_SLEEP_TIMEOUT_EN.
module ulpb_sleep_sched #(
  parameter int NUM_REQ      = 4,
  parameter int CNT_W        = 8,
  parameter int GUARD_CYCLES = 8,
  parameter int IDLE_CYCLES  = 16,
  parameter int REQ_TIMEOUT  = 32
) (
  input  logic               CLKIN,
  input  logic               RESETn,
  input  logic [NUM_REQ-1:0] SLP_VOTE,
  input  logic               BUS_BUSY,
  input  logic               WAKE_REQ,
  input  logic               ISO_STAT,
  output logic               SLEEP_REQ,
  output logic [2:0]         SCHED_STATE,
  output logic [CNT_W-1:0]   SLEEP_CNT,
  output logic               TIMEOUT_ERR
);

  // RELEASE_ISO levels, matching IO_HOLD / IO_RELEASE in ulpb_def.v
  localparam logic IO_HOLD    = 1'b0;
  localparam logic IO_RELEASE = 1'b1;

  localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ALL1   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYCLES);
  localparam logic [CNT_W-1:0] IDLE_LAST  = CNT_W'(IDLE_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_BOOT   = 3'd0,
    ST_GUARD  = 3'd1,
    ST_ARMED  = 3'd2,
    ST_REQ    = 3'd3,
    ST_ASLEEP = 3'd4
  } state_t;

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic             sleep_req_r;
  logic [CNT_W-1:0] sleep_cnt_r;
  logic             idle_ok_s;
  logic             iso_hold_s;
  logic             iso_release_s;
  logic [CNT_W-1:0] sleep_cnt_next_s;

  // Counters must be able to hold every threshold they are compared against
  if (NUM_REQ < 1 || IDLE_CYCLES < 1 || IDLE_CYCLES >= (1 << CNT_W) ||
      GUARD_CYCLES < 0 || GUARD_CYCLES >= (1 << CNT_W) ||
      REQ_TIMEOUT < 1 || REQ_TIMEOUT > (1 << CNT_W)) begin : g_param_check
    $error("ulpb_sleep_sched: parameter out of range");
  end

`ifdef ULPB_SLEEP_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(REQ_TIMEOUT - 1);
  logic timeout_err_r;
`endif

  // Idle qualification, isolation decode and saturating sleep count
  always_comb begin
    idle_ok_s     = (&SLP_VOTE) & ~BUS_BUSY & ~WAKE_REQ;
    iso_hold_s    = (ISO_STAT == IO_HOLD);
    iso_release_s = (ISO_STAT == IO_RELEASE);
    if (sleep_cnt_r == CNT_ALL1) begin
      sleep_cnt_next_s = sleep_cnt_r;
    end else begin
      sleep_cnt_next_s = sleep_cnt_r + CNT_ONE;
    end
  end

  // Scheduler FSM with registered outputs
  always_ff @(posedge CLKIN or negedge RESETn) begin
    if (!RESETn) begin
      state_r       <= ST_BOOT;
      cnt_r         <= CNT_ZERO;
      sleep_req_r   <= 1'b0;
      sleep_cnt_r   <= CNT_ZERO;
`ifdef ULPB_SLEEP_TIMEOUT_EN
      timeout_err_r <= 1'b0;
`endif
    end else begin
`ifdef ULPB_SLEEP_TIMEOUT_EN
      timeout_err_r <= 1'b0;
`endif
      case (state_r)
        ST_BOOT: begin
          sleep_req_r <= 1'b0;
          cnt_r       <= CNT_ZERO;
          if (iso_hold_s) begin
            state_r <= ST_ASLEEP;
          end else begin
            state_r <= ST_GUARD;
          end
        end

        ST_GUARD: begin
          sleep_req_r <= 1'b0;
          if (iso_hold_s) begin
            state_r <= ST_ASLEEP;
            cnt_r   <= CNT_ZERO;
          end else if (cnt_r >= GUARD_LAST) begin
            state_r <= ST_ARMED;
            cnt_r   <= CNT_ZERO;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end

        // Any non-idle sample restarts the whole qualification window
        ST_ARMED: begin
          if (iso_hold_s) begin
            state_r     <= ST_ASLEEP;
            sleep_req_r <= 1'b0;
            cnt_r       <= CNT_ZERO;
          end else if (!idle_ok_s) begin
            sleep_req_r <= 1'b0;
            cnt_r       <= CNT_ZERO;
          end else if (cnt_r == IDLE_LAST) begin
            state_r     <= ST_REQ;
            sleep_req_r <= 1'b1;
            cnt_r       <= CNT_ZERO;
          end else begin
            sleep_req_r <= 1'b0;
            cnt_r       <= cnt_r + CNT_ONE;
          end
        end

        // Request is committed: activity no longer matters, only isolation
        ST_REQ: begin
          if (iso_hold_s) begin
            state_r     <= ST_ASLEEP;
            sleep_req_r <= 1'b0;
            sleep_cnt_r <= sleep_cnt_next_s;
            cnt_r       <= CNT_ZERO;
`ifdef ULPB_SLEEP_TIMEOUT_EN
          end else if (cnt_r == TO_LAST) begin
            state_r       <= ST_GUARD;
            sleep_req_r   <= 1'b0;
            timeout_err_r <= 1'b1;
            cnt_r         <= CNT_ZERO;
          end else begin
            sleep_req_r <= 1'b1;
            cnt_r       <= cnt_r + CNT_ONE;
          end
`else
          end else begin
            sleep_req_r <= 1'b1;
            cnt_r       <= CNT_ZERO;
          end
`endif
        end

        ST_ASLEEP: begin
          sleep_req_r <= 1'b0;
          cnt_r       <= CNT_ZERO;
          if (iso_release_s) begin
            state_r <= ST_GUARD;
          end else begin
            state_r <= ST_ASLEEP;
          end
        end

        default: begin
          state_r     <= ST_BOOT;
          sleep_req_r <= 1'b0;
          cnt_r       <= CNT_ZERO;
        end
      endcase
    end
  end

  assign SLEEP_REQ   = sleep_req_r;
  assign SCHED_STATE = state_r;
  assign SLEEP_CNT   = sleep_cnt_r;
`ifdef ULPB_SLEEP_TIMEOUT_EN
  assign TIMEOUT_ERR = timeout_err_r;
`else
  assign TIMEOUT_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_ulpb_sleep_sched.sv
// Self-checking bench for ulpb_sleep_sched: directed scenarios plus randomized
// traffic compared against an event-level reference model.
module tb_ulpb_sleep_sched;

  localparam int NUM_REQ      = 4;
  localparam int CNT_W        = 8;
  localparam int GUARD_CYCLES = 8;
  localparam int IDLE_CYCLES  = 16;
  localparam int REQ_TIMEOUT  = 32;
  localparam int CNT_MAX      = (1 << CNT_W) - 1;
  localparam logic HOLD = 1'b0;
  localparam logic REL  = 1'b1;

  logic               CLKIN = 1'b0;
  logic               RESETn;
  logic [NUM_REQ-1:0] SLP_VOTE;
  logic               BUS_BUSY;
  logic               WAKE_REQ;
  logic               ISO_STAT;
  logic               SLEEP_REQ;
  logic [2:0]         SCHED_STATE;
  logic [CNT_W-1:0]   SLEEP_CNT;
  logic               TIMEOUT_ERR;

  always #5 CLKIN = ~CLKIN;

  ulpb_sleep_sched #(
    .NUM_REQ(NUM_REQ), .CNT_W(CNT_W), .GUARD_CYCLES(GUARD_CYCLES),
    .IDLE_CYCLES(IDLE_CYCLES), .REQ_TIMEOUT(REQ_TIMEOUT)
  ) dut (
    .CLKIN(CLKIN), .RESETn(RESETn), .SLP_VOTE(SLP_VOTE), .BUS_BUSY(BUS_BUSY),
    .WAKE_REQ(WAKE_REQ), .ISO_STAT(ISO_STAT), .SLEEP_REQ(SLEEP_REQ),
    .SCHED_STATE(SCHED_STATE), .SLEEP_CNT(SLEEP_CNT), .TIMEOUT_ERR(TIMEOUT_ERR)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: phase plus elapsed-time bookkeeping in spec terms
  int m_state;      // 0 boot,1 guard,2 armed,3 req,4 asleep
  int m_guard_age;  // edges spent in guard
  int m_streak;     // consecutive idle samples seen while armed
  int m_req_age;    // edges spent waiting in req
  int m_sleeps;
  bit m_req;
  bit m_terr;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_state = 0; m_guard_age = 0; m_streak = 0; m_req_age = 0;
    m_sleeps = 0; m_req = 1'b0; m_terr = 1'b0;
  endfunction

  function automatic void model_step();
    bit idle = (SLP_VOTE == {NUM_REQ{1'b1}}) && !BUS_BUSY && !WAKE_REQ;
    bit hold = (ISO_STAT == HOLD);
    m_terr = 1'b0;
    case (m_state)
      0: if (hold) m_state = 4; else begin m_state = 1; m_guard_age = 0; end
      1: if (hold) m_state = 4;
         else begin
           m_guard_age++;
           if (m_guard_age > GUARD_CYCLES) begin m_state = 2; m_streak = 0; end
         end
      2: if (hold) m_state = 4;
         else if (idle) begin
           m_streak++;
           if (m_streak == IDLE_CYCLES) begin m_state = 3; m_req = 1'b1; m_req_age = 0; end
         end else m_streak = 0;
      3: if (hold) begin
           m_state = 4; m_req = 1'b0;
           if (m_sleeps < CNT_MAX) m_sleeps++;
         end else begin
           m_req_age++;
`ifdef ULPB_SLEEP_TIMEOUT_EN
           if (m_req_age == REQ_TIMEOUT) begin
             m_state = 1; m_guard_age = 0; m_req = 1'b0; m_terr = 1'b1;
           end
`endif
         end
      4: if (!hold) begin m_state = 1; m_guard_age = 0; end
      default: m_state = 0;
    endcase
  endfunction

  task automatic cycle();
    @(posedge CLKIN);
    model_step();
    #1;
    check_eq("sleep_req", SLEEP_REQ, m_req);
    check_eq("sched_state", SCHED_STATE, m_state);
    check_eq("sleep_cnt", SLEEP_CNT, m_sleeps);
    check_eq("timeout_err", TIMEOUT_ERR, m_terr);
  endtask

  task automatic edges_until_state(input int s, input int budget, output int n);
    n = 0;
    while (n <= budget && SCHED_STATE != 3'(s)) begin cycle(); n++; end
  endtask

  task automatic edges_until_req(input logic lvl, input int budget, output int n);
    n = 0;
    while (n <= budget && SLEEP_REQ !== lvl) begin cycle(); n++; end
  endtask

  task automatic sleep_once();
    int n;
    ISO_STAT = REL;
    edges_until_state(2, 30, n);
    edges_until_req(1'b1, 30, n);
    ISO_STAT = HOLD;
    cycle();
  endtask

  initial begin
    int n;
    SLP_VOTE = 4'hF; BUS_BUSY = 1'b0; WAKE_REQ = 1'b0; ISO_STAT = REL;
    RESETn = 1'b0;
    model_reset();
    #2;
    check_eq("rst_sleep_req", SLEEP_REQ, 32'd0);
    check_eq("rst_state", SCHED_STATE, 32'd0);
    check_eq("rst_sleep_cnt", SLEEP_CNT, 32'd0);
    check_eq("rst_timeout_err", TIMEOUT_ERR, 32'd0);
    #10 RESETn = 1'b1;

    // Basic entry
    edges_until_state(1, 5, n);   check_eq("boot_exit", n, 32'd1);
    edges_until_state(2, 20, n);  check_eq("guard_len", n, 32'd9);
    edges_until_req(1'b1, 30, n); check_eq("idle_latency", n, 32'd16);
    ISO_STAT = HOLD; cycle();
    check_eq("entry_req_low", SLEEP_REQ, 32'd0);
    check_eq("entry_cnt", SLEEP_CNT, 32'd1);
    check_eq("entry_state", SCHED_STATE, 32'd4);

    // Wake, then one busy sample restarts idle qualification
    ISO_STAT = REL;
    edges_until_state(1, 5, n);   check_eq("wake_guard", n, 32'd1);
    edges_until_state(2, 20, n);  check_eq("wake_rearm", n, 32'd9);
    repeat (10) cycle();
    BUS_BUSY = 1'b1; cycle(); BUS_BUSY = 1'b0;
    edges_until_req(1'b1, 40, n); check_eq("idle_restart", n, 32'd16);
    ISO_STAT = HOLD; cycle();
    check_eq("second_sleep_cnt", SLEEP_CNT, 32'd2);

    // A missing vote blocks the request
    ISO_STAT = REL;
    edges_until_state(2, 30, n);
    SLP_VOTE = 4'hF & ~(4'h1 << $urandom_range(0, 3));
    repeat (60) cycle();
    check_eq("vote_block_req", SLEEP_REQ, 32'd0);
    check_eq("vote_block_state", SCHED_STATE, 32'd2);

    // Unsolicited sleep from ARMED
    ISO_STAT = HOLD; cycle();
    check_eq("unsol_state", SCHED_STATE, 32'd4);
    check_eq("unsol_cnt", SLEEP_CNT, 32'd2);
    check_eq("unsol_req", SLEEP_REQ, 32'd0);
    SLP_VOTE = 4'hF;

    // Isolation never engages while requesting
    ISO_STAT = REL;
    edges_until_state(2, 30, n);
    edges_until_req(1'b1, 30, n);
`ifdef ULPB_SLEEP_TIMEOUT_EN
    edges_until_req(1'b0, 40, n); check_eq("timeout_len", n, 32'd32);
    check_eq("timeout_pulse", TIMEOUT_ERR, 32'd1);
    check_eq("timeout_state", SCHED_STATE, 32'd1);
    check_eq("timeout_cnt", SLEEP_CNT, 32'd2);
    cycle();
    check_eq("timeout_pulse_end", TIMEOUT_ERR, 32'd0);
`else
    repeat (40) cycle();
    check_eq("no_timeout_req", SLEEP_REQ, 32'd1);
    check_eq("no_timeout_err", TIMEOUT_ERR, 32'd0);
    check_eq("no_timeout_state", SCHED_STATE, 32'd3);
    ISO_STAT = HOLD; cycle();
`endif

    // Saturation of the sleep counter
    repeat (300) sleep_once();
    check_eq("cnt_saturate", SLEEP_CNT, 32'd255);

    // Asynchronous reset while requesting
    ISO_STAT = REL;
    edges_until_state(2, 30, n);
    edges_until_req(1'b1, 30, n);
    check_eq("pre_reset_req", SLEEP_REQ, 32'd1);
    RESETn = 1'b0;
    #2;
    check_eq("async_rst_req", SLEEP_REQ, 32'd0);
    check_eq("async_rst_state", SCHED_STATE, 32'd0);
    check_eq("async_rst_cnt", SLEEP_CNT, 32'd0);
    model_reset();
    #2 RESETn = 1'b1;

    // Randomized traffic with a loosely cooperative sleep controller
    for (int i = 0; i < 4000; i++) begin
      SLP_VOTE = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
      BUS_BUSY = ($urandom_range(0, 24) == 0);
      WAKE_REQ = ($urandom_range(0, 29) == 0);
      case (m_state)
        3:       ISO_STAT = ($urandom_range(0, 3) == 0) ? HOLD : REL;
        4:       ISO_STAT = ($urandom_range(0, 5) == 0) ? REL : HOLD;
        default: ISO_STAT = ($urandom_range(0, 149) == 0) ? HOLD : REL;
      endcase
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
